// File: rtl/cross_bar_mem_slave.sv
// Cross-bar base-interface responder: single-beat read/write against a small register-file memory,
// with parameterised ack and response latencies.
module cross_bar_mem_slave #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int ACK_DELAY  = 0,
  parameter int RESP_DELAY = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              resp,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [15:0]       err_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, ACK_WAIT, ACK, RESP_WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          dly_q, dly_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cmd_q, cmd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic                resp_q, resp_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [15:0]         err_q, err_d;
  logic [15:0]         drop_q, drop_d;
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
  logic                mem_we;
  logic                in_range;
  logic [IDX_W-1:0]    idx;

  // An address is valid only if every bit above the index field is zero.
  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = (addr_q >> IDX_W) == '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    dly_d   = dly_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    drop_d  = drop_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          cmd_d   = cmd;
          wdata_d = wdata;
          if (ACK_DELAY > 0) begin
            state_d = ACK_WAIT;
            dly_d   = 4'(ACK_DELAY);
          end else begin
            state_d = ACK;
          end
        end
      end
      ACK_WAIT: begin
        if (dly_q <= 4'd1) state_d = ACK;
        else               dly_d   = dly_q - 4'd1;
      end
      ACK: begin
        mem_we = cmd_q && in_range;
        if (!in_range && err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (RESP_DELAY > 0) begin
          state_d = RESP_WAIT;
          dly_d   = 4'(RESP_DELAY);
        end else begin
          state_d = RESP;
        end
      end
      RESP_WAIT: begin
        if (dly_q <= 4'd1) state_d = RESP;
        else               dly_d   = dly_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (req && state_q != IDLE && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    // Outputs are decoded from the next state so they leave the block straight from flops.
    ack_d   = (state_d == ACK);
    resp_d  = (state_d == RESP);
    busy_d  = (state_d != IDLE);
    rdata_d = (state_d == RESP && !cmd_q && in_range) ? mem_q[idx] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      dly_q   <= '0;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: the memory is reset word by word, so it maps to flops rather than a RAM macro.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign ack      = ack_q;
  assign resp     = resp_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign err_cnt  = err_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_cross_bar_mem_slave.sv
// Randomised bench for cross_bar_mem_slave: two latency configurations checked against a
// transaction-level model, plus a long-running instance that drives drop_cnt into saturation.
module tb_cross_bar_mem_slave;

  localparam int AD_A = 0,  RD_A = 1;
  localparam int AD_B = 3,  RD_B = 2;
  localparam int AD_C = 15, RD_C = 15;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn, c_rstn;
  logic        req, cmd, sel, c_req;
  logic [31:0] addr, wdata;

  logic        a_ack, a_resp, a_busy, b_ack, b_resp, b_busy, c_ack, c_resp, c_busy;
  logic [31:0] a_rdata, b_rdata, c_rdata;
  logic [15:0] a_err, a_drop, b_err, b_drop, c_err, c_drop;

  cross_bar_mem_slave #(.ACK_DELAY(AD_A), .RESP_DELAY(RD_A)) u_dut_a (
    .aclk(aclk), .aresetn(aresetn), .req(req & ~sel), .addr(addr), .cmd(cmd), .wdata(wdata),
    .ack(a_ack), .resp(a_resp), .rdata(a_rdata), .busy(a_busy), .err_cnt(a_err), .drop_cnt(a_drop));

  cross_bar_mem_slave #(.ACK_DELAY(AD_B), .RESP_DELAY(RD_B)) u_dut_b (
    .aclk(aclk), .aresetn(aresetn), .req(req & sel), .addr(addr), .cmd(cmd), .wdata(wdata),
    .ack(b_ack), .resp(b_resp), .rdata(b_rdata), .busy(b_busy), .err_cnt(b_err), .drop_cnt(b_drop));

  cross_bar_mem_slave #(.ACK_DELAY(AD_C), .RESP_DELAY(RD_C)) u_dut_c (
    .aclk(aclk), .aresetn(c_rstn), .req(c_req), .addr(32'h0), .cmd(1'b0), .wdata(32'h0),
    .ack(c_ack), .resp(c_resp), .rdata(c_rdata), .busy(c_busy), .err_cnt(c_err), .drop_cnt(c_drop));

  logic        o_ack, o_resp, o_busy;
  logic [31:0] o_rdata;
  logic [15:0] o_err, o_drop;
  assign o_ack   = sel ? b_ack   : a_ack;
  assign o_resp  = sel ? b_resp  : a_resp;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_err   = sel ? b_err   : a_err;
  assign o_drop  = sel ? b_drop  : a_drop;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_m  [2][16];
  logic [15:0] err_m  [2];
  logic [15:0] drop_m [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s sel=%0d t=%0t got=%h exp=%h", tag, sel, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) mem_m[s][i] = '0;
      err_m[s]  = '0;
      drop_m[s] = '0;
    end
  endtask

  // One transaction on the selected instance; returns in the first idle cycle with req low.
  task automatic do_txn(input logic [31:0] ta, input logic tc, input logic [31:0] td,
                        input int drop_pct);
    int          s, ad, rd, last;
    logic        in_r;
    logic [3:0]  ix;
    logic [31:0] exp_rd;
    s      = sel ? 1 : 0;
    ad     = sel ? AD_B : AD_A;
    rd     = sel ? RD_B : RD_A;
    in_r   = (ta < 32'd16);
    ix     = ta[3:0];
    exp_rd = (!tc && in_r) ? mem_m[s][ix] : 32'h0;
    req = 1'b1; addr = ta; cmd = tc; wdata = td;
    tick();
    last = 3 + ad + rd;
    for (int k = 1; k <= last; k++) begin
      check("ack",   {31'h0, o_ack},  {31'h0, k == 1 + ad});
      check("resp",  {31'h0, o_resp}, {31'h0, k == 2 + ad + rd});
      check("busy",  {31'h0, o_busy}, {31'h0, k < last});
      check("rdata", o_rdata, (k == 2 + ad + rd) ? exp_rd : 32'h0);
      if (k == 1 + ad) begin
        if (!in_r)   err_m[s]++;
        else if (tc) mem_m[s][ix] = td;
      end
      if (k == last) begin
        check("err_cnt",  {16'h0, o_err},  {16'h0, err_m[s]});
        check("drop_cnt", {16'h0, o_drop}, {16'h0, drop_m[s]});
        req = 1'b0;
      end else begin
        req = ($urandom_range(99) < drop_pct);
        if (req) begin
          drop_m[s]++;
          addr  = $urandom_range(15);
          cmd   = 1'($urandom);
          wdata = $urandom;
        end
        tick();
      end
    end
  endtask

  task automatic random_txns(input int n);
    logic [31:0] ta;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(3))
        0:       ta = $urandom;
        1:       ta = 32'd16;
        default: ta = $urandom_range(15);
      endcase
      do_txn(ta, 1'($urandom), $urandom, 20);
      repeat ($urandom_range(2)) tick();
    end
  endtask

  initial begin
    aresetn = 1'b0; c_rstn = 1'b0;
    req = 1'b0; cmd = 1'b0; addr = '0; wdata = '0; sel = 1'b0; c_req = 1'b0;
    clear_model();
    fork
      begin : saturation
        repeat (3) @(posedge aclk);
        #1 c_rstn = 1'b1;
        c_req = 1'b1;
        // Each 33-cycle period holds one accepted request and 32 dropped ones.
        repeat (3300) @(posedge aclk);
        #1 check("c_drop_mid", {16'h0, c_drop}, 32'd3200);
        repeat (68000 - 3300) @(posedge aclk);
        #1 check("c_drop_sat", {16'h0, c_drop}, 32'h0000_FFFF);
        repeat (200) @(posedge aclk);
        #1 check("c_drop_hold", {16'h0, c_drop}, 32'h0000_FFFF);
        check("c_err", {16'h0, c_err}, 32'h0);
        c_req = 1'b0;
      end
      begin : main
        repeat (2) tick();
        for (int s = 0; s < 2; s++) begin
          sel = s[0];
          #1;
          check("rst_ack",   {31'h0, o_ack},  32'h0);
          check("rst_resp",  {31'h0, o_resp}, 32'h0);
          check("rst_busy",  {31'h0, o_busy}, 32'h0);
          check("rst_rdata", o_rdata, 32'h0);
          check("rst_err",   {16'h0, o_err},  32'h0);
          check("rst_drop",  {16'h0, o_drop}, 32'h0);
        end
        sel = 1'b0;
        aresetn = 1'b1;
        repeat (3) tick();

        do_txn(32'd3, 1'b1, 32'hDEAD_BEEF, 0);
        repeat (5) tick();
        do_txn(32'd3, 1'b0, 32'h0, 0);
        do_txn(32'd16, 1'b0, 32'h0, 0);
        do_txn(32'h100, 1'b1, 32'hCAFE_F00D, 0);
        do_txn(32'd0, 1'b0, 32'h0, 0);
        do_txn(32'd7, 1'b1, 32'h5555_AAAA, 100);
        do_txn(32'd7, 1'b0, 32'h0, 100);
        random_txns(150);

        sel = 1'b1;
        #1;
        do_txn(32'd0, 1'b0, 32'h0, 0);
        do_txn(32'd9, 1'b1, 32'h0BAD_F00D, 50);
        do_txn(32'd9, 1'b0, 32'h0, 0);
        random_txns(150);

        // Reset in the cycle after ack discards the transaction and clears memory and counters.
        sel = 1'b0;
        #1;
        req = 1'b1; addr = 32'd5; cmd = 1'b1; wdata = 32'h1234;
        tick();
        check("mid_ack", {31'h0, o_ack}, 32'h1);
        req = 1'b0;
        tick();
        aresetn = 1'b0;
        #1;
        check("mid_ack0",   {31'h0, o_ack},  32'h0);
        check("mid_resp0",  {31'h0, o_resp}, 32'h0);
        check("mid_busy0",  {31'h0, o_busy}, 32'h0);
        check("mid_rdata0", o_rdata, 32'h0);
        check("mid_err0",   {16'h0, o_err},  32'h0);
        check("mid_drop0",  {16'h0, o_drop}, 32'h0);
        clear_model();
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
          tick();
          check("post_rst_resp", {31'h0, o_resp}, 32'h0);
          check("post_rst_busy", {31'h0, o_busy}, 32'h0);
        end
        do_txn(32'd5, 1'b0, 32'h0, 0);
        random_txns(40);
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cross_bar_mem_slave.md
# cross_bar_mem_slave

Responder end of the cross-bar base interface: accepts single-beat read/write requests from the arbiter controller's base master port, acknowledges each one, executes it against an internal register-file memory and returns a response pulse with read data. Used as the default slave behind the cross-bar and as the reference target for cross-bar verification. Ack and response latencies are parameterised so the bench can stress master wait states.

## Interface

- ADDR_W, 32, width of addr (word address)
- DATA_W, 32, width of wdata/rdata
- MEM_DEPTH, 16, number of DATA_W words; power of 2, ≥2
- ACK_DELAY, 0, extra idle cycles between request capture and ack (0..15)
- RESP_DELAY, 1, extra idle cycles between ack and resp (0..15)

Reset is asynchronous and active-low; one clock.

- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- req  in  1  request strobe, one-cycle pulse from master
- addr  in  ADDR_W  word address, valid when req=1
- cmd  in  1  0 = read, 1 = write; valid when req=1
- wdata  in  DATA_W  write data, valid when req=1 and cmd=1
- ack  out  1  request accepted, one-cycle pulse
- resp  out  1  transaction complete, one-cycle pulse
- rdata  out  DATA_W  read data, valid only when resp=1
- busy  out  1  transaction in flight (state ≠ IDLE)
- err_cnt  out  16  count of out-of-range accesses, saturating
- drop_cnt  out  16  count of req pulses ignored while busy, saturating

## Operation

- FSM states: IDLE, ACK_WAIT, ACK, RESP_WAIT, RESP.
- IDLE: on req=1 capture addr, cmd, wdata into holding registers; go ACK_WAIT if ACK_DELAY>0, else ACK.
- ACK_WAIT: down-counter loaded with ACK_DELAY; go ACK when it reaches 1 after ACK_DELAY cycles.
- ACK: ack=1 for this cycle only; go RESP_WAIT if RESP_DELAY>0, else RESP.
- RESP_WAIT: same counter reloaded with RESP_DELAY; go RESP after RESP_DELAY cycles.
- RESP: resp=1 one cycle; rdata = mem[captured addr] for reads, '0 for writes; return to IDLE.
- Minimum one cycle between ack and resp is mandatory (master samples resp only after leaving its ack-wait state).
- Write commit: on the edge leaving ACK (i.e. before resp); visible to any later read.
- In range: addr < MEM_DEPTH (all upper bits zero). Out of range: write dropped, read returns '0, err_cnt += 1 (at ACK), ack/resp still issued.
- req in any state other than IDLE: ignored, drop_cnt += 1; no effect on the in-flight transaction.
- Counters saturate at 16'hFFFF.
- rdata = '0 in every cycle where resp=0.

## Timing

- Reset (async assert): state IDLE; ack=0, resp=0, rdata='0, busy=0, err_cnt=0, drop_cnt=0; all memory words = '0; holding registers cleared; in-flight transaction discarded, its write does not commit.
- Reset deassert: first req sampled on the first rising edge with aresetn=1.
- req high in cycle N → busy=1 from N+1; ack in cycle N+1+ACK_DELAY; resp in cycle N+2+ACK_DELAY+RESP_DELAY; IDLE again in the following cycle.
- Defaults (0,1): ack at N+1, resp at N+3, next req accepted at N+4 onward.
- Back-to-back: req in the same cycle as resp is dropped (state ≠ IDLE); req the cycle after resp is accepted.
- Outputs ack, resp, rdata, busy, counters are registered (no combinational input-to-output path).

## Test plan

- Defaults, write addr=3 wdata=0xDEADBEEF at cycle 10, then read addr=3 at cycle 20 → ack at 11, resp at 13 with rdata=0; read ack at 21, resp at 23 with rdata=0xDEADBEEF.
- ACK_DELAY=3, RESP_DELAY=2, read addr=0 after reset at cycle 5 → ack at 9, resp at 12, rdata=0, busy high cycles 6–12.
- Read addr=16 and write addr=0x100 (MEM_DEPTH=16) → both acked and responded, rdata=0, err_cnt=2, mem unchanged.
- req at N, second req at N+2 (during transaction) → only first served, drop_cnt=1; req at resp cycle also dropped, drop_cnt=2.
- Write addr=5 0x1234, aresetn pulsed low in the cycle after ack → ack/resp/busy 0 immediately, no resp issued, subsequent read addr=5 returns 0.
- Drive 65537 out-of-range accesses (or force counter near max) → err_cnt holds 16'hFFFF, no wrap.
